// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared ALUOp, funct and ALU operation encodings
package alu_exec_unit_pkg;

  // ALUOp encodings driven by main control
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // R-type funct field, low four bits
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_SLT = 4'b1010;

  // ALU operation select (gout)
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_exec_unit_alu_ctrl_dec.sv
// rtl/alu_exec_unit_alu_ctrl_dec.sv - ALUOp/funct to 3-bit ALU operation decoder
module alu_ctrl_dec
  import alu_exec_unit_pkg::*;
(
  input  logic       i_aluop1,
  input  logic       i_aluop0,
  input  logic [3:0] i_funct,
  output logic [2:0] o_gout
);

  // Decode ALUOp first; funct only matters for R-type. Unlisted codes fall back to add.
  always_comb begin
    o_gout = ALU_ADD;
    case ({i_aluop1, i_aluop0})
      ALUOP_MEM:   o_gout = ALU_ADD;
      ALUOP_BEQ:   o_gout = ALU_SUB;
      ALUOP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_gout = ALU_ADD;
          FN_SUB:  o_gout = ALU_SUB;
          FN_AND:  o_gout = ALU_AND;
          FN_OR:   o_gout = ALU_OR;
          FN_SLT:  o_gout = ALU_SLT;
          default: o_gout = ALU_ADD;
        endcase
      end
      default:     o_gout = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: ALU control, ALU, PC adders, result register
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             aluop1,
  input  logic             aluop0,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] branch_offset,
  output logic [2:0]       gout,
  output logic [WIDTH-1:0] sum,
  output logic             zout,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] sum_q,
  output logic             zout_q
);

  logic [2:0]       w_gout;
  logic [WIDTH-1:0] w_sum;
  logic             w_lt;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] r_sum_q;
  logic             r_zout_q;

  alu_ctrl_dec u_alu_ctrl_dec (
    .i_aluop1 (aluop1),
    .i_aluop0 (aluop0),
    .i_funct  (funct),
    .o_gout   (w_gout)
  );

  // Signed compare handles the overflow cases that the sign of a-b would get wrong
  assign w_lt = ($signed(a) < $signed(b));

  // ALU result selected by the decoded operation; unused codes give zero
  always_comb begin
    w_sum = '0;
    case (w_gout)
      ALU_AND: w_sum = a & b;
      ALU_OR:  w_sum = a | b;
      ALU_ADD: w_sum = a + b;
      ALU_SUB: w_sum = a - b;
      ALU_SLT: w_sum = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_sum = '0;
    endcase
  end

  assign w_pc_plus4    = pc + WIDTH'(4);
  assign branch_target = w_pc_plus4 + branch_offset;
  assign pc_plus4      = w_pc_plus4;
  assign gout          = w_gout;
  assign sum           = w_sum;
  assign zout          = (w_sum == '0);

  // Capture result and zero flag when enabled; reset clears them immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum_q  <= '0;
      r_zout_q <= 1'b0;
    end else if (en) begin
      r_sum_q  <= w_sum;
      r_zout_q <= (w_sum == '0);
    end
  end

  assign sum_q  = r_sum_q;
  assign zout_q = r_zout_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        aluop1;
  logic        aluop0;
  logic [3:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] branch_offset;
  logic [2:0]  gout;
  logic [31:0] sum;
  logic        zout;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] sum_q;
  logic        zout_q;

  int n_cmp = 0;
  int n_err = 0;

  // reference copy of the registered outputs
  logic [31:0] m_sum_q;
  logic        m_zout_q;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .aluop1        (aluop1),
    .aluop0        (aluop0),
    .funct         (funct),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .branch_offset (branch_offset),
    .gout          (gout),
    .sum           (sum),
    .zout          (zout),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .sum_q         (sum_q),
    .zout_q        (zout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // operation chosen by the instruction, as a table lookup
  function automatic logic [2:0] m_gout(input logic [1:0] op, input logic [3:0] fn);
    logic [2:0] rtype_tbl [16];
    for (int i = 0; i < 16; i++) rtype_tbl[i] = 3'b010;
    rtype_tbl[2]  = 3'b110;
    rtype_tbl[4]  = 3'b000;
    rtype_tbl[5]  = 3'b001;
    rtype_tbl[10] = 3'b111;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b10) return rtype_tbl[fn];
    return 3'b010;
  endfunction

  // result from plain integer arithmetic
  function automatic logic [31:0] m_sum(input logic [2:0] g, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = longint'(ux) - (x[31] ? 64'sd4294967296 : 64'sd0);
    sy = longint'(uy) - (y[31] ? 64'sd4294967296 : 64'sd0);
    case (g)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return 32'((ux + uy) % 64'd4294967296);
      3'b110:  return 32'((ux + 64'd4294967296 - uy) % 64'd4294967296);
      3'b111:  return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] fn, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] ipc, input logic [31:0] ioff);
    aluop1 = op[1];
    aluop0 = op[0];
    funct = fn;
    a = ia;
    b = ib;
    pc = ipc;
    branch_offset = ioff;
    #1;
  endtask

  task automatic check_comb(input string tag);
    logic [2:0]  eg;
    logic [31:0] es;
    logic [31:0] epc4;
    eg = m_gout({aluop1, aluop0}, funct);
    es = m_sum(eg, a, b);
    epc4 = 32'(({32'd0, pc} + 64'd4) % 64'd4294967296);
    chk({tag, ".gout"}, {29'd0, gout}, {29'd0, eg});
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".zout"}, {31'd0, zout}, {31'd0, (es == 32'd0)});
    chk({tag, ".pc4"}, pc_plus4, epc4);
    chk({tag, ".btgt"}, branch_target, 32'(({32'd0, epc4} + {32'd0, branch_offset}) % 64'd4294967296));
  endtask

  // one clock edge: update the model from the inputs held across the edge, then check
  task automatic tick(input string tag);
    logic [31:0] es;
    @(posedge clk);
    es = m_sum(m_gout({aluop1, aluop0}, funct), a, b);
    if (!reset && en) begin
      m_sum_q = es;
      m_zout_q = (es == 32'd0);
    end
    #1;
    chk({tag, ".sum_q"}, sum_q, m_sum_q);
    chk({tag, ".zout_q"}, {31'd0, zout_q}, {31'd0, m_zout_q});
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [3:0]  r_fn;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  fn_pool [8];
    fn_pool[0] = 4'b0000; fn_pool[1] = 4'b0010; fn_pool[2] = 4'b0100; fn_pool[3] = 4'b0101;
    fn_pool[4] = 4'b1010; fn_pool[5] = 4'b1010; fn_pool[6] = 4'b1111; fn_pool[7] = 4'b0110;

    reset = 1'b1;
    en = 1'b0;
    m_sum_q = 32'd0;
    m_zout_q = 1'b0;
    drive(2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
    #3;
    chk("reset.sum_q", sum_q, 32'd0);
    chk("reset.zout_q", {31'd0, zout_q}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // lw path
    en = 1'b1;
    drive(2'b00, 4'b0000, 32'h00000010, 32'h00000004, 32'h0, 32'h0);
    check_comb("lw");
    chk("lw.sum_const", sum, 32'h00000014);
    tick("lw");
    chk("lw.sum_q_const", sum_q, 32'h00000014);

    // beq taken
    drive(2'b01, 4'b0000, 32'h12345678, 32'h12345678, 32'h00000008, 32'h00000010);
    check_comb("beq");
    chk("beq.gout_const", {29'd0, gout}, 32'd6);
    chk("beq.btgt_const", branch_target, 32'h0000001C);
    chk("beq.pc4_const", pc_plus4, 32'h0000000C);
    tick("beq");

    // R-type logic
    drive(2'b10, 4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h100, 32'hFFFFFFF0);
    check_comb("and");
    chk("and.sum_const", sum, 32'h00F000F0);
    drive(2'b10, 4'b0101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h100, 32'hFFFFFFF0);
    check_comb("or");
    chk("or.sum_const", sum, 32'hFFF0FFF0);

    // slt signed and overflow-correct
    drive(2'b10, 4'b1010, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h0);
    check_comb("slt1");
    chk("slt1.sum_const", sum, 32'd1);
    drive(2'b10, 4'b1010, 32'h80000000, 32'h00000001, 32'h0, 32'h0);
    check_comb("slt2");
    chk("slt2.sum_const", sum, 32'd1);
    drive(2'b10, 4'b1010, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    check_comb("slt3");
    chk("slt3.zout_const", {31'd0, zout}, 32'd1);

    // wrap and default decode
    drive(2'b10, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFC, 32'h00000008);
    check_comb("wrap");
    chk("wrap.sum_const", sum, 32'd0);
    chk("wrap.pc4_const", pc_plus4, 32'd0);
    drive(2'b10, 4'b1111, 32'h5, 32'h3, 32'h0, 32'h0);
    check_comb("dflt");
    chk("dflt.gout_const", {29'd0, gout}, 32'd2);
    drive(2'b11, 4'b0010, 32'h5, 32'h3, 32'h0, 32'h0);
    check_comb("op11");

    // reset mid-operation, then hold with en low
    drive(2'b00, 4'b0000, 32'h00000010, 32'h00000004, 32'h0, 32'h0);
    en = 1'b1;
    tick("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    m_sum_q = 32'd0;
    m_zout_q = 1'b0;
    chk("async_rst.sum_q", sum_q, 32'd0);
    chk("async_rst.zout_q", {31'd0, zout_q}, 32'd0);
    check_comb("under_rst");
    @(negedge clk);
    reset = 1'b0;
    en = 1'b0;
    tick("hold_rst0");
    tick("hold_rst1");
    en = 1'b1;
    drive(2'b01, 4'b0000, 32'h77, 32'h77, 32'h0, 32'h0);
    tick("load_zero");
    en = 1'b0;
    drive(2'b00, 4'b0000, 32'h1, 32'h2, 32'h0, 32'h0);
    tick("hold0");
    tick("hold1");

    // randomized sweep against the reference model
    for (int i = 0; i < 300; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_fn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : fn_pool[$urandom_range(0, 7)];
      r_a = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = r_a;
        1:       r_b = r_a ^ 32'h80000000;
        2:       r_b = 32'h80000000;
        default: r_b = $urandom;
      endcase
      en = ($urandom_range(0, 3) != 0);
      drive(r_op, r_fn, r_a, r_b, $urandom, $urandom);
      check_comb("rnd");
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage datapath for the single-cycle MIPS-subset processor.
- Combines the ALU control decoder (ALUOp plus funct to a 3-bit ALU operation), the 32-bit ALU with zero flag, and the two 32-bit PC adders (PC+4 and branch target).
- All results are available combinationally; the ALU result and zero flag are also registered for later pipelining and observation.

Parameters:
- WIDTH, 32, datapath width of ALU operands, result and PC adders.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high; clears registered outputs
- en  input  1  load enable for the registered result/zero
- aluop1  input  1  ALUOp bit 1 from main control
- aluop0  input  1  ALUOp bit 0 from main control
- funct  input  4  instruction bits [3:0]
- a  input  WIDTH  operand A (register read data 1)
- b  input  WIDTH  operand B (ALUSrc mux output)
- pc  input  WIDTH  current program counter
- branch_offset  input  WIDTH  sign-extended immediate already shifted left by 2
- gout  output  3  decoded ALU operation
- sum  output  WIDTH  combinational ALU result
- zout  output  1  combinational zero flag, high when sum == 0
- pc_plus4  output  WIDTH  pc + 4
- branch_target  output  WIDTH  pc_plus4 + branch_offset
- sum_q  output  WIDTH  registered sum
- zout_q  output  1  registered zout

Behaviour:
- ALU control (combinational), {aluop1,aluop0}:
  - 00 -> gout 010 (add; lw/sw)
  - 01 -> gout 110 (subtract; beq)
  - 11 -> gout 010
  - 10 (R-type), decoded by funct:
    - 0000 -> 010 add
    - 0010 -> 110 sub
    - 0100 -> 000 and
    - 0101 -> 001 or
    - 1010 -> 111 slt
    - any other funct -> 010
- ALU (combinational), by gout:
  - 000 -> a & b
  - 001 -> a | b
  - 010 -> a + b, modulo 2^WIDTH, no carry or overflow output
  - 110 -> a - b, modulo 2^WIDTH
  - 111 -> 1 if a < b as two's-complement signed, else 0; the comparison is overflow-correct (not just the sign bit of a-b); upper bits are zero
  - 011, 100, 101 -> sum = 0
- zout = (sum == 0), for every operation.
- Adders (combinational): wrap modulo 2^WIDTH, no carry out. pc_plus4 = pc + 4; branch_target = pc_plus4 + branch_offset.
- Registers:
  - Reset asserted (asynchronous): sum_q = 0 and zout_q = 0 immediately.
  - Rising clk with en=1 and reset low: sum_q <= sum, zout_q <= zout (latency 1).
  - en=0: registered outputs hold.
  - Reset has priority over en. Deassertion is sampled on the next rising edge.
- Combinational outputs are unaffected by reset and clock.
- No X propagation from unused funct codes; every input combination yields a defined output.

Decomposition:
- Shared package holds:
  - ALUOp encodings: ALUOP_MEM=2'b00, ALUOP_BEQ=2'b01, ALUOP_RTYPE=2'b10
  - funct constants: FN_ADD=4'b0000, FN_SUB=4'b0010, FN_AND=4'b0100, FN_OR=4'b0101, FN_SLT=4'b1010
  - gout constants: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111
- One sub-module is natural: alu_ctrl_dec (ALUOp/funct to gout).
- ALU and adders stay inline.

Test Plan:
- lw path: aluop=00, a=0x00000010, b=0x00000004 -> gout=010, sum=0x00000014, zout=0; after clk with en=1, sum_q=0x00000014.
- beq taken: aluop=01, a=b=0x12345678, pc=0x00000008, branch_offset=0x00000010 -> gout=110, sum=0, zout=1, pc_plus4=0x0000000C, branch_target=0x0000001C.
- R-type logic: aluop=10, a=0xF0F0F0F0, b=0x0FF00FF0; funct=0100 -> sum=0x00F000F0; funct=0101 -> sum=0xFFF0FFF0.
- slt signed and overflow: aluop=10, funct=1010, a=0xFFFFFFFF, b=0x00000001 -> sum=1; a=0x80000000, b=0x00000001 -> sum=1; a=0x7FFFFFFF, b=0xFFFFFFFF -> sum=0, zout=1.
- Wrap and default decode: aluop=10, funct=0000, a=0xFFFFFFFF, b=1 -> sum=0, zout=1. funct=1111 -> gout=010. pc=0xFFFFFFFC -> pc_plus4=0.
- Reset mid-operation: sum_q=0x14 held, assert reset between edges -> sum_q=0 and zout_q=0 immediately; en=0 after release -> values hold across edges.
